isp_tpg: RTL and testbench

Raw Bayer test-pattern generator and sensor-timing source; the transmitting end of the pclk/href/vsync/raw pixel stream that ISP stages (dgain, blc, …) consume.
Produces frame/line timing plus selectable synthetic pixel data, so the ISP chain can run and be checked without a sensor.
Sits at the head of the ISP pipe, muxed against the sensor input.

---
 rtl/isp_tpg.sv | 205 ++++++++++++++++++++
 tb/tb_isp_tpg.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/isp_tpg.sv
// Raw Bayer test-pattern generator and sensor-timing source.
// Produces href/vsync timing plus synthetic pixels (bars, ramp, solid, checker).
module isp_tpg #(
  parameter int BITS        = 8,
  parameter int WIDTH       = 1280,
  parameter int HEIGHT      = 960,
  parameter int HBLANK      = 160,
  parameter int VBLANK      = 20,
  parameter int VSYNC_LINES = 2
) (
  input  logic            pclk,
  input  logic            rst,
  input  logic            enable,
  input  logic [1:0]      mode,
  input  logic [BITS-1:0] solid_val,
  output logic            out_href,
  output logic            out_vsync,
  output logic [BITS-1:0] out_raw,
  output logic            frame_start,
  output logic            busy,
  output logic [15:0]     frame_cnt
);

  localparam int H_TOTAL    = WIDTH + HBLANK;
  localparam int V_TOTAL    = HEIGHT + VBLANK;
  localparam int H_W        = $clog2(H_TOTAL);
  localparam int V_W        = $clog2(V_TOTAL);
  localparam int BAR_W      = WIDTH / 8;
  localparam int BC_W       = $clog2(BAR_W);
  localparam int BAR_STEP_I = ((1 << BITS) - 1) / 7;

  localparam logic [H_W-1:0]  H_LAST   = H_W'(H_TOTAL - 1);
  localparam logic [V_W-1:0]  V_LAST   = V_W'(V_TOTAL - 1);
  localparam logic [H_W-1:0]  H_ACT    = H_W'(WIDTH);
  localparam logic [V_W-1:0]  V_VB     = V_W'(VBLANK);
  localparam logic [V_W-1:0]  V_VS     = V_W'(VSYNC_LINES);
  localparam logic [H_W-1:0]  H_ZERO   = H_W'(0);
  localparam logic [V_W-1:0]  V_ZERO   = V_W'(0);
  localparam logic [BC_W-1:0] BC_LAST  = BC_W'(BAR_W - 1);
  localparam logic [BC_W-1:0] BC_ZERO  = BC_W'(0);
  localparam logic [BITS-1:0] PIX_MAX  = {BITS{1'b1}};
  localparam logic [BITS-1:0] PIX_ZERO = {BITS{1'b0}};
  localparam logic [BITS-1:0] BAR_STEP = BITS'(BAR_STEP_I);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t          state_r;
  logic [H_W-1:0]  h_cnt_r;
  logic [V_W-1:0]  v_cnt_r;
  logic [BC_W-1:0] bar_cnt_r;
  logic [2:0]      bar_idx_r;
  logic [1:0]      mode_r;
  logic [BITS-1:0] solid_r;

  logic            live_s;
  logic            h_last_s;
  logic            v_last_s;
  logic            frame_first_s;
  logic            frame_end_s;
  logic [H_W-1:0]  h_nxt_s;
  logic [V_W-1:0]  v_nxt_s;
  logic [BC_W-1:0] bar_cnt_nxt_s;
  logic [2:0]      bar_idx_nxt_s;
  logic            vsync_s;
  logic            href_s;
  logic [15:0]     x_s;
  logic [15:0]     y_s;
  logic [BITS-1:0] pix_s;
  logic [BITS-1:0] raw_s;

  // Counter stepping, timing decode and pattern selection for the current position.
  always_comb begin
    live_s        = 1'b0;
    h_nxt_s       = H_ZERO;
    v_nxt_s       = V_ZERO;
    bar_cnt_nxt_s = BC_ZERO;
    bar_idx_nxt_s = 3'd0;
    pix_s         = PIX_ZERO;
    raw_s         = PIX_ZERO;

    // An idle generator treats the enable cycle itself as position (0,0).
    case (state_r)
      ST_IDLE: live_s = enable;
      ST_RUN:  live_s = 1'b1;
      default: live_s = 1'b0;
    endcase

    h_last_s      = (h_cnt_r == H_LAST);
    v_last_s      = (v_cnt_r == V_LAST);
    frame_end_s   = h_last_s && v_last_s;
    frame_first_s = (h_cnt_r == H_ZERO) && (v_cnt_r == V_ZERO);

    if (h_last_s) begin
      h_nxt_s = H_ZERO;
      if (v_last_s) begin
        v_nxt_s = V_ZERO;
      end else begin
        v_nxt_s = v_cnt_r + V_W'(1);
      end
    end else begin
      h_nxt_s = h_cnt_r + H_W'(1);
      v_nxt_s = v_cnt_r;
    end

    // Bar index tracks h_cnt/BAR_W incrementally; saturates through the blanking tail.
    if (h_last_s) begin
      bar_cnt_nxt_s = BC_ZERO;
      bar_idx_nxt_s = 3'd0;
    end else if (bar_cnt_r == BC_LAST) begin
      bar_cnt_nxt_s = BC_ZERO;
      if (bar_idx_r != 3'd7) begin
        bar_idx_nxt_s = bar_idx_r + 3'd1;
      end else begin
        bar_idx_nxt_s = bar_idx_r;
      end
    end else begin
      bar_cnt_nxt_s = bar_cnt_r + BC_W'(1);
      bar_idx_nxt_s = bar_idx_r;
    end

    vsync_s = (v_cnt_r < V_VS);
    href_s  = (v_cnt_r >= V_VB) && (h_cnt_r < H_ACT);
    x_s     = 16'(h_cnt_r);
    y_s     = 16'(v_cnt_r) - 16'(VBLANK);

    case (mode_r)
      2'd0:    pix_s = BITS'(bar_idx_r) * BAR_STEP;
      2'd1:    pix_s = BITS'(h_cnt_r);
      2'd2:    pix_s = solid_r;
      2'd3: begin
        if (x_s[3] ^ y_s[3]) begin
          pix_s = PIX_MAX;
        end else begin
          pix_s = PIX_ZERO;
        end
      end
      default: pix_s = PIX_ZERO;
    endcase

    if (href_s) begin
      raw_s = pix_s;
    end else begin
      raw_s = PIX_ZERO;
    end
  end

  // Run/idle state, position counters, per-frame settings and registered outputs.
  always_ff @(posedge pclk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      h_cnt_r     <= H_ZERO;
      v_cnt_r     <= V_ZERO;
      bar_cnt_r   <= BC_ZERO;
      bar_idx_r   <= 3'd0;
      mode_r      <= 2'd0;
      solid_r     <= PIX_ZERO;
      out_href    <= 1'b0;
      out_vsync   <= 1'b0;
      out_raw     <= PIX_ZERO;
      frame_start <= 1'b0;
      busy        <= 1'b0;
      frame_cnt   <= 16'd0;
    end else if (live_s) begin
      h_cnt_r     <= h_nxt_s;
      v_cnt_r     <= v_nxt_s;
      bar_cnt_r   <= bar_cnt_nxt_s;
      bar_idx_r   <= bar_idx_nxt_s;
      out_href    <= href_s;
      out_vsync   <= vsync_s;
      out_raw     <= raw_s;
      frame_start <= frame_first_s;
      busy        <= 1'b1;
      // (0,0) is always vertical blanking, so latching here never affects a visible pixel.
      if (frame_first_s) begin
        mode_r  <= mode;
        solid_r <= solid_val;
      end else begin
        mode_r  <= mode_r;
        solid_r <= solid_r;
      end
      if (frame_end_s) begin
        frame_cnt <= frame_cnt + 16'd1;
        state_r   <= enable ? ST_RUN : ST_IDLE;
      end else begin
        frame_cnt <= frame_cnt;
        state_r   <= ST_RUN;
      end
    end else begin
      state_r     <= ST_IDLE;
      h_cnt_r     <= H_ZERO;
      v_cnt_r     <= V_ZERO;
      bar_cnt_r   <= BC_ZERO;
      bar_idx_r   <= 3'd0;
      out_href    <= 1'b0;
      out_vsync   <= 1'b0;
      out_raw     <= PIX_ZERO;
      frame_start <= 1'b0;
      busy        <= 1'b0;
    end
  end

endmodule

// File: tb/tb_isp_tpg.sv
// Bench for isp_tpg: table-driven checkpoints, directed corner sequences and
// randomized stimulus against a frame-position reference model.
module tb_isp_tpg;

  localparam int BITS = 8;
  localparam int W    = 16;
  localparam int H    = 4;
  localparam int HB   = 4;
  localparam int VB   = 3;
  localparam int VS   = 1;
  localparam int LINE  = W + HB;
  localparam int FRAME = LINE * (H + VB);

  logic            pclk = 1'b0;
  logic            rst;
  logic            enable;
  logic [1:0]      mode;
  logic [BITS-1:0] solid_val;
  logic            out_href;
  logic            out_vsync;
  logic [BITS-1:0] out_raw;
  logic            frame_start;
  logic            busy;
  logic [15:0]     frame_cnt;

  isp_tpg #(
    .BITS(BITS), .WIDTH(W), .HEIGHT(H), .HBLANK(HB), .VBLANK(VB), .VSYNC_LINES(VS)
  ) dut (
    .pclk(pclk), .rst(rst), .enable(enable), .mode(mode), .solid_val(solid_val),
    .out_href(out_href), .out_vsync(out_vsync), .out_raw(out_raw),
    .frame_start(frame_start), .busy(busy), .frame_cnt(frame_cnt)
  );

  always #5 pclk = ~pclk;

  int checks = 0;
  int errors = 0;

  // Reference model: a frame is just a position 0..FRAME-1 since its start.
  bit m_run = 1'b0;
  int m_pos = 0;
  int m_fc  = 0;
  int m_mode = 0;
  int m_solid = 0;
  int e_vs, e_hr, e_raw, e_fs, e_bs;

  function automatic int pattern(int md, int sv, int x, int y);
    case (md)
      0: return (x / (W / 8)) * (((1 << BITS) - 1) / 7);
      1: return x % (1 << BITS);
      2: return sv;
      default: return ((((x / 8) % 2) ^ ((y / 8) % 2)) != 0) ? (1 << BITS) - 1 : 0;
    endcase
  endfunction

  task automatic model_edge();
    int h, v;
    if (rst) begin
      m_run = 1'b0; m_pos = 0; m_fc = 0;
      m_mode = 0; m_solid = 0;
      e_vs = 0; e_hr = 0; e_raw = 0; e_fs = 0; e_bs = 0;
    end else if (m_run || enable) begin
      if (m_pos == 0) begin
        m_mode = int'(mode);
        m_solid = int'(solid_val);
      end
      h = m_pos % LINE;
      v = m_pos / LINE;
      e_vs = (v < VS) ? 1 : 0;
      e_hr = (v >= VB && h < W) ? 1 : 0;
      e_raw = (e_hr != 0) ? pattern(m_mode, m_solid, h, v - VB) : 0;
      e_fs = (m_pos == 0) ? 1 : 0;
      e_bs = 1;
      if (m_pos == FRAME - 1) begin
        m_fc = (m_fc + 1) % 65536;
        m_pos = 0;
        m_run = enable;
      end else begin
        m_pos = m_pos + 1;
        m_run = 1'b1;
      end
    end else begin
      e_vs = 0; e_hr = 0; e_raw = 0; e_fs = 0; e_bs = 0;
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge pclk);
    model_edge();
    #1;
    chk("model_vsync", int'(out_vsync), e_vs);
    chk("model_href", int'(out_href), e_hr);
    chk("model_raw", int'(out_raw), e_raw);
    chk("model_frame_start", int'(frame_start), e_fs);
    chk("model_busy", int'(busy), e_bs);
    chk("model_frame_cnt", int'(frame_cnt), m_fc);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  typedef struct {
    bit       rst;
    bit       en;
    bit [1:0] md;
    bit [7:0] sv;
    int       ncyc;
    bit       vs;
    bit       hr;
    bit [7:0] raw;
    bit       fs;
    bit       bs;
    bit [15:0] fc;
  } vec_t;

  vec_t tbl[10];

  initial begin
    rst = 1'b1; enable = 1'b0; mode = 2'd0; solid_val = 8'd0;

    // Frame 1 in ramp mode: checkpoints at known positions of the first frame.
    tbl[0] = '{1'b1, 1'b0, 2'd1, 8'h00,  2, 1'b0, 1'b0, 8'd0,  1'b0, 1'b0, 16'd0};
    tbl[1] = '{1'b0, 1'b1, 2'd1, 8'h00,  1, 1'b1, 1'b0, 8'd0,  1'b1, 1'b1, 16'd0};
    tbl[2] = '{1'b0, 1'b1, 2'd1, 8'h00,  1, 1'b1, 1'b0, 8'd0,  1'b0, 1'b1, 16'd0};
    tbl[3] = '{1'b0, 1'b1, 2'd1, 8'h00, 58, 1'b0, 1'b0, 8'd0,  1'b0, 1'b1, 16'd0};
    tbl[4] = '{1'b0, 1'b1, 2'd1, 8'h00,  1, 1'b0, 1'b1, 8'd0,  1'b0, 1'b1, 16'd0};
    tbl[5] = '{1'b0, 1'b1, 2'd1, 8'h00,  5, 1'b0, 1'b1, 8'd5,  1'b0, 1'b1, 16'd0};
    tbl[6] = '{1'b0, 1'b1, 2'd1, 8'h00, 10, 1'b0, 1'b1, 8'd15, 1'b0, 1'b1, 16'd0};
    tbl[7] = '{1'b0, 1'b1, 2'd1, 8'h00,  1, 1'b0, 1'b0, 8'd0,  1'b0, 1'b1, 16'd0};
    tbl[8] = '{1'b0, 1'b1, 2'd1, 8'h00, 63, 1'b0, 1'b0, 8'd0,  1'b0, 1'b1, 16'd1};
    tbl[9] = '{1'b0, 1'b1, 2'd1, 8'h00,  1, 1'b1, 1'b0, 8'd0,  1'b1, 1'b1, 16'd1};

    for (int i = 0; i < 10; i++) begin
      rst = tbl[i].rst; enable = tbl[i].en; mode = tbl[i].md; solid_val = tbl[i].sv;
      run(tbl[i].ncyc);
      chk($sformatf("tbl%0d_vsync", i), int'(out_vsync), int'(tbl[i].vs));
      chk($sformatf("tbl%0d_href", i), int'(out_href), int'(tbl[i].hr));
      chk($sformatf("tbl%0d_raw", i), int'(out_raw), int'(tbl[i].raw));
      chk($sformatf("tbl%0d_fs", i), int'(frame_start), int'(tbl[i].fs));
      chk($sformatf("tbl%0d_busy", i), int'(busy), int'(tbl[i].bs));
      chk($sformatf("tbl%0d_fcnt", i), int'(frame_cnt), int'(tbl[i].fc));
    end

    // Enable dropped at clk 30 of frame 2: frame still runs to completion.
    run(29);
    enable = 1'b0;
    run(110);
    chk("drop_last_busy", int'(busy), 1);
    chk("drop_last_fcnt", int'(frame_cnt), 2);
    run(1);
    chk("drop_idle_busy", int'(busy), 0);
    chk("drop_idle_vsync", int'(out_vsync), 0);
    chk("drop_idle_fcnt", int'(frame_cnt), 2);
    run(5);
    chk("idle_raw", int'(out_raw), 0);

    // Re-enable in solid mode, then change settings mid-frame.
    mode = 2'd2; solid_val = 8'h5A; enable = 1'b1;
    run(1);
    chk("reen_fs", int'(frame_start), 1);
    run(65);
    chk("solid_raw_a", int'(out_raw), 8'h5A);
    mode = 2'd1; solid_val = 8'h11;
    run(55);
    chk("solid_raw_b", int'(out_raw), 8'h5A);
    chk("solid_href_b", int'(out_href), 1);
    run(20);
    chk("next_fs", int'(frame_start), 1);
    chk("next_fcnt", int'(frame_cnt), 3);
    run(65);
    chk("next_ramp_raw", int'(out_raw), 5);

    // Colour bars on the first active line.
    mode = 2'd0;
    run(74 + 1 + 60);
    for (int h = 0; h < W; h++) begin
      chk($sformatf("bars_x%0d", h), int'(out_raw), (h / 2) * 36);
      step();
    end

    // Checker: every active line is 8 x 0 then 8 x 255.
    mode = 2'd3;
    run(63 + 1 + 60);
    for (int y = 0; y < H; y++) begin
      for (int h = 0; h < LINE; h++) begin
        if (h < W) chk($sformatf("chk_y%0d_x%0d", y, h), int'(out_raw), (h < 8) ? 0 : 255);
        step();
      end
    end

    // Reset mid-frame at clk 70, enable kept high.
    run(69);
    rst = 1'b1;
    run(1);
    chk("rst_href", int'(out_href), 0);
    chk("rst_vsync", int'(out_vsync), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_fcnt", int'(frame_cnt), 0);
    rst = 1'b0;
    run(1);
    chk("rst_restart_fs", int'(frame_start), 1);
    chk("rst_restart_vsync", int'(out_vsync), 1);

    // Randomized run: mostly-on enable, sporadic mode/level changes, rare reset.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 199) == 0) enable = ~enable;
      if ($urandom_range(0, 49) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 49) == 0) solid_val = 8'($urandom_range(0, 255));
      rst = ($urandom_range(0, 999) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
